cordic_div_scheduler: RTL and testbench

//  Round-robin scheduler that shares one iterative bfloat16 linear-CORDIC divider (z = y/x)

---
 rtl/cordic_div_scheduler_if.sv | 37 +++
 rtl/cordic_div_scheduler.sv | 142 ++++++++++++++
 tb/tb_cordic_div_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_div_scheduler_if.sv
// Bundle of the request, response and divider-side signals of cordic_div_scheduler.
// master: the environment (softmax lanes, response consumer, shared divider).
// slave : the scheduler itself.
interface cordic_div_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_x;
    logic [NUM_REQ*DATA_W-1:0] req_y;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_W-1:0]         rsp_data;
    logic [ID_W-1:0]           rsp_id;
    logic                      rsp_err;
    logic                      cordic_en;
    logic [DATA_W-1:0]         cordic_x;
    logic [DATA_W-1:0]         cordic_y;
    logic                      cordic_done;
    logic [DATA_W-1:0]         cordic_out;
    logic                      busy;

    modport master (
        output req_valid, req_x, req_y, rsp_ready, cordic_done, cordic_out,
        input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err,
               cordic_en, cordic_x, cordic_y, busy
    );

    modport slave (
        input  req_valid, req_x, req_y, rsp_ready, cordic_done, cordic_out,
        output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err,
               cordic_en, cordic_x, cordic_y, busy
    );
endinterface

// File: rtl/cordic_div_scheduler.sv
// Round-robin scheduler sharing one iterative bfloat16 CORDIC divider among NUM_REQ lanes.
// Latency: accept edge to rsp_valid = 22 cycles with a 20-cycle divider; one divide in flight.
// Backpressure: response held until rsp_ready; no new grant until the handshake completes.
//
// Ports: clk, rst_n (async active-low) plus bus (cordic_div_scheduler_if.slave) carrying
//   req_valid/req_ready/req_x/req_y, rsp_valid/rsp_ready/rsp_data/rsp_id/rsp_err,
//   cordic_en/cordic_x/cordic_y/cordic_done/cordic_out and busy.
// Optional feature macro: CORDIC_SCHED_TIMEOUT_EN adds a RUN-cycle watchdog that aborts
//   after TIMEOUT_CYC cycles with NaN data and rsp_err=1; otherwise rsp_err is tied low.
module cordic_div_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cordic_div_scheduler_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

    state_t              state_q;
    logic [ID_W-1:0]     rr_q;
    logic [ID_W-1:0]     rr_d;
    logic [ID_W-1:0]     id_q;
    logic [DATA_W-1:0]   x_q;
    logic [DATA_W-1:0]   y_q;
    logic [DATA_W-1:0]   data_q;
    logic                vld_q;
    logic                en_q;
    logic                busy_q;
    logic                grant_vld;
    logic [ID_W-1:0]     grant_idx;

`ifdef CORDIC_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]    cnt_q;
    logic                err_q;
`endif

    // First valid lane at or after rr_q, searching upward with wrap.
    always_comb begin
        int lane;
        lane      = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            lane = (int'(rr_q) + i) % NUM_REQ;
            if (!grant_vld && bus.req_valid[lane]) begin
                grant_vld = 1'b1;
                grant_idx = ID_W'(lane);
            end
        end
        rr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    // The grant is the only combinational output: the lane must see it in its request cycle.
    assign bus.req_ready = (state_q == IDLE && grant_vld) ? (NUM_REQ'(1) << grant_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
`ifdef CORDIC_SCHED_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        x_q     <= bus.req_x[int'(grant_idx)*DATA_W +: DATA_W];
                        y_q     <= bus.req_y[int'(grant_idx)*DATA_W +: DATA_W];
                        id_q    <= grant_idx;
                        rr_q    <= rr_d;
                        en_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    en_q    <= 1'b0;
`ifdef CORDIC_SCHED_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                    state_q <= RUN;
                end
                // cordic_done is sticky after a divide completes, so it is only trusted here,
                // after the load pulse has restarted the divider.
                RUN: begin
                    if (bus.cordic_done) begin
                        data_q  <= bus.cordic_out;
                        vld_q   <= 1'b1;
`ifdef CORDIC_SCHED_TIMEOUT_EN
                        err_q   <= 1'b0;
`endif
                        state_q <= RESP;
                    end
`ifdef CORDIC_SCHED_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        data_q  <= 16'h7FC0;
                        vld_q   <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        vld_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = vld_q;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_id    = id_q;
    assign bus.cordic_en = en_q;
    assign bus.cordic_x  = x_q;
    assign bus.cordic_y  = y_q;
    assign bus.busy      = busy_q;
`ifdef CORDIC_SCHED_TIMEOUT_EN
    assign bus.rsp_err   = err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_cordic_div_scheduler.sv
// Self-checking bench for cordic_div_scheduler: a transaction-level model of the scheduler
// plus a 20-cycle divider stand-in, compared against the DUT every cycle at the falling edge.
// Directed phases pin the model with literal latencies, grant orders and data values.
module tb_cordic_div_scheduler;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int TO = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cordic_div_scheduler_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

    cordic_div_scheduler #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT_CYC(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Divider stand-in: result is an arbitrary but deterministic function of the operands.
    function automatic logic [W-1:0] div_fn(input logic [W-1:0] x, input logic [W-1:0] y);
        return y - x + 16'h3F80;
    endfunction
    assign bus.cordic_out = div_fn(bus.cordic_x, bus.cordic_y);

    // Divider timing: loaded on the edge that sees cordic_en, i runs -5..14 over 20 cycles,
    // done rises for i==14 and stays high until the next load.
    int   dcnt      = 0;
    logic div_never = 1'b0;
    initial begin
        logic en_s;
        bus.cordic_done = 1'b1;   // stale done from a previous divide
        forever begin
            @(negedge clk);
            en_s = bus.cordic_en;
            @(posedge clk);
            #1;
            if (en_s) begin
                dcnt = 1;
                bus.cordic_done = 1'b0;
            end else if (dcnt > 0 && dcnt < 20) begin
                dcnt++;
            end
            if (dcnt == 20 && !div_never) bus.cordic_done = 1'b1;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model state: a request is in flight from its grant until the response handshake.
    int           m_busy, m_age, m_resp, m_rr, m_id, m_err;
    logic [W-1:0] m_x, m_y, m_data;

    // Observation logs for the directed checks.
    int           g_lane[$];
    int           g_cyc[$];
    int           r_lat[$];
    logic [W-1:0] r_data[$];
    int           r_id[$];
    int           r_err[$];
    int           last_grant_cyc = 0;
    logic         prev_rv = 1'b0;

    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        int g, j;
        cyc++;
        if (!rst_n) begin
            m_busy = 0; m_age = 0; m_resp = 0; m_rr = 0; m_id = 0; m_err = 0;
            m_x = '0; m_y = '0; m_data = '0;
            chk("rst_req_ready", 32'(bus.req_ready), 0);
            chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
            chk("rst_rsp_data",  32'(bus.rsp_data), 0);
            chk("rst_rsp_id",    32'(bus.rsp_id), 0);
            chk("rst_rsp_err",   32'(bus.rsp_err), 0);
            chk("rst_cordic_en", 32'(bus.cordic_en), 0);
            chk("rst_cordic_x",  32'(bus.cordic_x), 0);
            chk("rst_cordic_y",  32'(bus.cordic_y), 0);
            chk("rst_busy",      32'(bus.busy), 0);
            prev_rv = 1'b0;
        end else begin
            exp_rdy = '0;
            g = -1;
            if (m_busy == 0) begin
                for (int i = 0; i < N; i++) begin
                    j = (m_rr + i) % N;
                    if (g < 0 && bus.req_valid[j]) g = j;
                end
                if (g >= 0) exp_rdy[g] = 1'b1;
            end
            chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
            chk("cordic_en", 32'(bus.cordic_en), 32'(m_busy != 0 && m_age == 1));
            chk("busy",      32'(bus.busy), 32'(m_busy != 0));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_resp != 0));
            chk("cordic_x",  32'(bus.cordic_x), 32'(m_x));
            chk("cordic_y",  32'(bus.cordic_y), 32'(m_y));
            if (m_resp != 0) begin
                chk("rsp_data", 32'(bus.rsp_data), 32'(m_data));
                chk("rsp_id",   32'(bus.rsp_id), 32'(m_id));
                chk("rsp_err",  32'(bus.rsp_err), 32'(m_err));
            end

            // Logging of what the DUT did, for the directed literal checks.
            for (int i = 0; i < N; i++) begin
                if (bus.req_ready[i]) begin
                    g_lane.push_back(i);
                    g_cyc.push_back(cyc);
                    last_grant_cyc = cyc;
                end
            end
            if (bus.rsp_valid && !prev_rv) begin
                r_lat.push_back(cyc - last_grant_cyc);
                r_data.push_back(bus.rsp_data);
                r_id.push_back(int'(bus.rsp_id));
                r_err.push_back(int'(bus.rsp_err));
            end
            prev_rv = bus.rsp_valid;

            // Advance the model across the coming rising edge.
            if (m_busy == 0) begin
                if (g >= 0) begin
                    m_busy = 1; m_age = 1; m_id = g; m_rr = (g + 1) % N;
                    m_x = bus.req_x[g*W +: W];
                    m_y = bus.req_y[g*W +: W];
                end
            end else if (m_resp != 0) begin
                if (bus.rsp_ready) begin
                    m_busy = 0; m_resp = 0;
                end
            end else if (m_age >= 2 && bus.cordic_done) begin
                m_resp = 1; m_data = div_fn(m_x, m_y); m_err = 0;
`ifdef CORDIC_SCHED_TIMEOUT_EN
            end else if (m_age >= 2 && (m_age - 1) == TO) begin
                m_resp = 1; m_data = 16'h7FC0; m_err = 1;
`endif
            end else begin
                m_age++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        g_lane.delete(); g_cyc.delete(); r_lat.delete();
        r_data.delete(); r_id.delete(); r_err.delete();
    endtask

    task automatic wait_grants(input int n, input int budget, input string name);
        int b = 0;
        while (g_lane.size() < n && b < budget) begin tick(1); b++; end
        chk(name, 32'(g_lane.size() >= n), 1);
    endtask

    task automatic wait_rsps(input int n, input int budget, input string name);
        int b = 0;
        while (r_lat.size() < n && b < budget) begin tick(1); b++; end
        chk(name, 32'(r_lat.size() >= n), 1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int b = 0;
        while ((bus.busy || bus.rsp_valid) && b < budget) begin tick(1); b++; end
        chk(name, 32'(bus.busy), 0);
    endtask

    task automatic set_lane(input int k, input logic [W-1:0] x, input logic [W-1:0] y);
        bus.req_x[k*W +: W] = x;
        bus.req_y[k*W +: W] = y;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int exp_rr[5] = '{0, 1, 2, 3, 0};
        bus.req_valid = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.rsp_ready = 1'b1;
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;

        // Round robin from reset: all lanes valid, response always accepted.
        clear_logs();
        for (int k = 0; k < N; k++) set_lane(k, 16'($urandom), 16'($urandom));
        bus.req_valid = '1;
        wait_grants(5, 200, "rr_grants_seen");
        bus.req_valid = '0;
        for (int i = 0; i < 5 && i < g_lane.size(); i++) chk("rr_order", 32'(g_lane[i]), 32'(exp_rr[i]));
        for (int i = 0; i < 4 && i + 1 < g_cyc.size(); i++) chk("rr_spacing", 32'(g_cyc[i+1] - g_cyc[i]), 23);
        wait_idle(60, "rr_idle");

        // Single lane 1: 2.0 / 1.0, stale done still high from the previous divide.
        clear_logs();
        set_lane(1, 16'h3F80, 16'h4000);
        bus.req_valid = 4'b0010;
        wait_grants(1, 10, "single_grant_seen");
        bus.req_valid = '0;
        wait_rsps(1, 40, "single_rsp_seen");
        if (r_lat.size() > 0) begin
            chk("single_latency", 32'(r_lat[0]), 22);
            chk("single_data", 32'(r_data[0]), 32'h4000);
            chk("single_id", 32'(r_id[0]), 1);
        end
        wait_idle(10, "single_idle");

        // Backpressure: response held 10 cycles while lane 0 waits.
        clear_logs();
        bus.rsp_ready = 1'b0;
        set_lane(3, 16'h3F00, 16'h40A0);
        bus.req_valid = 4'b1000;
        wait_grants(1, 10, "bp_grant_seen");
        bus.req_valid = 4'b0001;
        wait_rsps(1, 40, "bp_rsp_seen");
        tick(10);
        chk("bp_no_grant", 32'(g_lane.size()), 1);
        chk("bp_valid_held", 32'(bus.rsp_valid), 1);
        chk("bp_data_held", 32'(bus.rsp_data), 32'(16'h40A0 - 16'h3F00 + 16'h3F80));
        chk("bp_id_held", 32'(bus.rsp_id), 3);
        bus.rsp_ready = 1'b1;
        wait_grants(2, 10, "bp_next_grant_seen");
        bus.req_valid = '0;
        if (g_lane.size() > 1) chk("bp_next_lane", 32'(g_lane[1]), 0);
        wait_idle(40, "bp_idle");

        // Reset in RUN cycle 8, then rr must restart from 0.
        clear_logs();
        set_lane(2, 16'h4040, 16'h4100);
        bus.req_valid = 4'b0100;
        wait_grants(1, 10, "rstrun_grant_seen");
        bus.req_valid = '0;
        tick(8);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        clear_logs();
        bus.req_valid = 4'b1100;
        wait_grants(1, 10, "post_rst_grant_seen");
        bus.req_valid = '0;
        if (g_lane.size() > 0) chk("post_rst_lane", 32'(g_lane[0]), 2);
        wait_rsps(1, 40, "post_rst_rsp_seen");
        if (r_id.size() > 0) chk("post_rst_id", 32'(r_id[0]), 2);
        wait_idle(10, "post_rst_idle");

        // Randomized traffic with random backpressure and lanes dropping requests.
        clear_logs();
        for (int c = 0; c < 1500; c++) begin
            bus.req_valid = N'($urandom);
            if ($urandom_range(0, 7) == 0) set_lane($urandom_range(0, N-1), 16'($urandom), 16'($urandom));
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            tick(1);
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        chk("rand_enough_rsps", 32'(r_lat.size() >= 30), 1);
        wait_idle(60, "rand_idle");

        // Divider never finishes.
        clear_logs();
        div_never = 1'b1;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b1000;
        wait_grants(1, 10, "to_grant_seen");
        bus.req_valid = '0;
        tick(45);
`ifdef CORDIC_SCHED_TIMEOUT_EN
        chk("to_valid", 32'(bus.rsp_valid), 1);
        chk("to_err", 32'(bus.rsp_err), 1);
        chk("to_data", 32'(bus.rsp_data), 32'h7FC0);
        if (r_lat.size() > 0) chk("to_latency", 32'(r_lat[0]), 34);
        bus.rsp_ready = 1'b1;
        tick(2);
        chk("to_idle", 32'(bus.busy), 0);
`else
        chk("to_valid", 32'(bus.rsp_valid), 0);
        chk("to_busy", 32'(bus.busy), 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
